// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, byte type and bit-period constants
// used by the receive path and its buffering.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  // Clocks per bit and per half bit at the system clock / baud ratio in use.
  localparam int BCLK  = 434;
  localparam int HBCLK = 217;

  // Four 10-bit characters of line silence.
  localparam int TIMEOUT_CYC_DEF = 4 * 10 * BCLK;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_ram.sv
// Storage array for the receive FIFO: one synchronous write port and one
// asynchronous read port so the head entry can fall through combinationally.
module uart_rx_fifo_ram
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  uart_byte_t        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output uart_byte_t        rdata_o
);

  uart_byte_t mem_q [2**ADDR_W];

  // NOTE: the array has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : uart_rx_fifo_ram

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver with sticky overrun.
// Optional idle timeout is compiled in with `define UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2  = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  uart_byte_t        rx_data,
  input  logic              rx_done,
  input  logic              rd_en,
  output uart_byte_t        rd_data,
  output logic              empty,
  output logic              full,
  output logic [DEPTH_LOG2:0] count,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              rx_timeout
);

  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                overrun_q, overrun_d;
  logic                push, pop, drop;
  uart_byte_t          ram_rdata;

  // Extra pointer MSB separates the full and empty cases when the low bits match.
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign pop  = rd_en && !empty;
  assign push = rx_done && (!full || rd_en);
  assign drop = rx_done && full && !rd_en;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (drop)         overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  uart_rx_fifo_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i (rx_data),
    .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rdata_o (ram_rdata)
  );

  assign rd_data = empty ? '0 : ram_rdata;
  assign overrun = overrun_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int                IDLE_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);

  logic [IDLE_W-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (push || pop || empty) idle_d = '0;
    else if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end

  assign rx_timeout = (idle_q == IDLE_MAX) && !empty;
`else
  assign rx_timeout = 1'b0;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model;
// timeout checks follow UART_RX_FIFO_TIMEOUT_EN when it is defined.
module tb_uart_rx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 2**DEPTH_LOG2;
  localparam int T_CYC      = 20;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [7:0]          rx_data;
  logic                rx_done;
  logic                rd_en;
  logic [7:0]          rd_data;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                overrun;
  logic                ovr_clr;
  logic                rx_timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: byte queue, sticky flag, edge index of last activity.
  logic [7:0] mq[$];
  bit         m_ovr;
  int         cyc;
  int         last_evt;

  uart_rx_fifo #(
    .DEPTH_LOG2  (DEPTH_LOG2),
    .TIMEOUT_CYC (T_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr),
    .rx_timeout (rx_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_timeout();
`ifdef UART_RX_FIFO_TIMEOUT_EN
    return (mq.size() > 0) && ((cyc - last_evt) >= T_CYC);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".rd_data"}, 32'(rd_data), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
    check({tag, ".count"},   32'(count),   32'(mq.size()));
    check({tag, ".empty"},   32'(empty),   32'(mq.size() == 0));
    check({tag, ".full"},    32'(full),    32'(mq.size() == DEPTH));
    check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    check({tag, ".timeout"}, 32'(rx_timeout), 32'(exp_timeout()));
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr    = 1'b0;
    last_evt = cyc;
  endtask

  // One clock: drive inputs, advance the model, sample 1 ns after the edge.
  task automatic cycle(input string tag, input logic done, input logic [7:0] data,
                       input logic rd, input logic clr);
    bit pre_empty, do_pop, do_push;
    rx_done   = done;
    rx_data   = data;
    rd_en     = rd;
    ovr_clr   = clr;
    pre_empty = (mq.size() == 0);
    do_pop    = rd && !pre_empty;
    do_push   = done && ((mq.size() < DEPTH) || rd);
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(data);
    if (done && !do_push) m_ovr = 1'b1;
    else if (clr)         m_ovr = 1'b0;
    @(posedge clk);
    cyc++;
    if (do_push || do_pop || pre_empty) last_evt = cyc;
    #1;
    rx_done = 1'b0;
    rd_en   = 1'b0;
    ovr_clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_done = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
    cyc = 0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    #4;

    // 1: asynchronous reset while partially filled
    for (int i = 0; i < 3; i++) cycle("fill3", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid.count",   32'(count),   32'd0);
    check("rst_mid.empty",   32'(empty),   32'd1);
    check("rst_mid.overrun", 32'(overrun), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("post_rst_idle", 1'b0, 8'hEE, 1'b0, 1'b0);

    // 2: ordering and fall-through
    cycle("ord_push", 1'b1, 8'hA5, 1'b0, 1'b0);
    cycle("ord_push", 1'b1, 8'h5A, 1'b0, 1'b0);
    cycle("ord_push", 1'b1, 8'h3C, 1'b0, 1'b0);
    check("ord.head", 32'(rd_data), 32'hA5);
    check("ord.cnt3", 32'(count),   32'd3);
    for (int i = 0; i < 3; i++) cycle("ord_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    check("ord.empty_data", 32'(rd_data), 32'h00);
    cycle("pop_when_empty", 1'b0, 8'h00, 1'b1, 1'b0);

    // 3: fill to full, drop on overflow, sticky flag and clear
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    check("fill.full",  32'(full),  32'd1);
    check("fill.cnt16", 32'(count), 32'd16);
    cycle("ovf_push", 1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf.overrun", 32'(overrun), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain.order", 32'(rd_data), 32'(i));
      cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("ovf.still_sticky", 32'(overrun), 32'd1);
    cycle("ovr_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    check("ovr_clr.overrun", 32'(overrun), 32'd0);

    // Drop and clear in the same cycle: set must win
    for (int i = 0; i < DEPTH; i++) cycle("refill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    cycle("set_vs_clr", 1'b1, 8'hEE, 1'b0, 1'b1);
    check("set_vs_clr.overrun", 32'(overrun), 32'd1);
    cycle("clr2", 1'b0, 8'h00, 1'b0, 1'b1);

    // 4: simultaneous push and pop while full, then while empty
    cycle("full_pushpop", 1'b1, 8'h77, 1'b1, 1'b0);
    check("full_pushpop.cnt", 32'(count),   32'd16);
    check("full_pushpop.ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < DEPTH; i++) cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
    check("last_out_empty", 32'(empty), 32'd1);
    cycle("empty_pushpop", 1'b1, 8'h11, 1'b1, 1'b0);
    check("empty_pushpop.cnt",  32'(count),   32'd1);
    check("empty_pushpop.data", 32'(rd_data), 32'h11);
    cycle("drain3", 1'b0, 8'h00, 1'b1, 1'b0);

    // 5: pointer wrap with one byte in flight
    for (int i = 0; i < 40; i++) begin
      cycle("wrap", 1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
      check("wrap.cnt_le1", 32'(count <= 1), 32'd1);
    end
    cycle("wrap_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // 6: idle timeout
    cycle("to_push", 1'b1, 8'h99, 1'b0, 1'b0);
    for (int i = 0; i < T_CYC - 1; i++) cycle("to_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    check("to.before", 32'(rx_timeout), 32'd0);
    cycle("to_idle_last", 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    check("to.asserted", 32'(rx_timeout), 32'd1);
`else
    check("to.tied_off", 32'(rx_timeout), 32'd0);
`endif
    cycle("to_idle_sat", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("to_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    check("to.dropped", 32'(rx_timeout), 32'd0);
    for (int i = 0; i < T_CYC + 5; i++) cycle("to_empty_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 99) < 55), 8'($urandom),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_rx_fifo
